// File: rtl/dht_pkg.sv
// dht_pkg: frame constants, FSM encoding and a sizing helper shared by the DHT reader.
package dht_pkg;
  localparam int FRAME_BITS = 40;
  localparam int BYTE_W = 8;
  localparam int US_PER_MS = 1000;
  typedef enum logic [3:0] {
    S_WAIT, S_START, S_REL, S_RSP_L, S_RSP_H, S_BIT_L, S_BIT_H, S_DONE, S_ERR
  } state_e;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/dht_us_tick.sv
// dht_us_tick: divides clk by DIV into a one-clk enable pulse (1 us tick).
module dht_us_tick #(
  parameter int DIV = 50
) (
  input  logic clk,
  input  logic sys_rst_n,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == W'(DIV - 1);
  always_comb cnt_d = tick ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge sys_rst_n)
    if (!sys_rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/dht_sensor_reader.sv
// dht_sensor_reader: single-wire humidity/temperature reader with checksum and edge-timeout flags.
// Define DHT_GLITCH_FILTER_EN to put a 3-tick majority filter after the line synchroniser.
module dht_sensor_reader
  import dht_pkg::*;
#(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int POLL_MS       = 1000,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 200,
  parameter bit AUTO_POLL     = 1'b1
) (
  input  logic        clk,
  input  logic        sys_rst_n,
  input  logic        trig,
  inout  wire         dht_io,
  output logic [15:0] humidity,
  output logic [15:0] temperature,
  output logic        data_valid,
  output logic        crc_err,
  output logic        timeout_err,
  output logic        busy
);
  localparam int POLL_TICKS = POLL_MS * US_PER_MS;
  localparam int CW = $clog2(max3(POLL_TICKS, START_LOW_US, TIMEOUT_US) + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] hi_q, hi_d;
  logic [5:0] bit_q, bit_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic [15:0] hum_q, hum_d, tmp_q, tmp_d;
  logic dv_q, dv_d, ce_q, ce_d, te_q, te_d, oe_q, oe_d, prev_q, prev_d;
  logic [1:0] sync_q, sync_d;
  logic tick, lvl, fall, rise, hit;
  logic [BYTE_W-1:0] sum;

  dht_us_tick #(.DIV(CLK_FREQ_HZ / 1_000_000)) u_tick (
    .clk(clk),
    .sys_rst_n(sys_rst_n),
    .tick(tick)
  );

  assign dht_io = oe_q ? 1'b0 : 1'bz;
  assign sync_d = {sync_q[0], dht_io};

`ifdef DHT_GLITCH_FILTER_EN
  logic [2:0] flt_q, flt_d;
  assign flt_d = tick ? {flt_q[1:0], sync_q[1]} : flt_q;
  assign lvl = (flt_q[0] & flt_q[1]) | (flt_q[0] & flt_q[2]) | (flt_q[1] & flt_q[2]);
  always_ff @(posedge clk or negedge sys_rst_n)
    if (!sys_rst_n) flt_q <= 3'b111;
    else flt_q <= flt_d;
`else
  assign lvl = sync_q[1];
`endif

  // Edges are only seen on tick samples so every width is measured in whole microseconds.
  assign prev_d = tick ? lvl : prev_q;
  assign fall = tick & prev_q & ~lvl;
  assign rise = tick & ~prev_q & lvl;

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    bit_d = bit_q;
    sh_d = sh_q;
    hum_d = hum_q;
    tmp_d = tmp_q;
    dv_d = 1'b0;
    ce_d = 1'b0;
    te_d = 1'b0;
    sum = sh_q[4*BYTE_W +: BYTE_W] + sh_q[3*BYTE_W +: BYTE_W] + sh_q[2*BYTE_W +: BYTE_W] + sh_q[BYTE_W +: BYTE_W];
    hit = (state_q == S_REL || state_q == S_RSP_H || state_q == S_BIT_H) ? fall : rise;
    case (state_q)
      S_WAIT:
        if (trig || (AUTO_POLL && tick && cnt_q == CW'(POLL_TICKS - 1))) begin
          state_d = S_START;
          cnt_d = '0;
          sh_d = '0;
          bit_d = '0;
        end else if (tick) cnt_d = cnt_q + 1'b1;
      S_START:
        if (tick) begin
          state_d = cnt_q == CW'(START_LOW_US - 1) ? S_REL : S_START;
          cnt_d = cnt_q == CW'(START_LOW_US - 1) ? '0 : cnt_q + 1'b1;
        end
      S_REL, S_RSP_L, S_RSP_H, S_BIT_L, S_BIT_H:
        if (hit) begin
          state_d = state_q == S_REL ? S_RSP_L : state_q == S_RSP_L ? S_RSP_H :
                    state_q == S_RSP_H ? S_BIT_L : state_q == S_BIT_L ? S_BIT_H :
                    bit_q == 6'(FRAME_BITS - 1) ? S_DONE : S_BIT_L;
          cnt_d = '0;
          hi_d = '0;
          if (state_q == S_BIT_H) begin
            sh_d = {sh_q[FRAME_BITS-2:0], hi_q > 8'(BIT_THRESH_US)};
            bit_d = bit_q + 1'b1;
          end
        end else if (tick) begin
          state_d = cnt_q == CW'(TIMEOUT_US - 1) ? S_ERR : state_q;
          cnt_d = cnt_q + 1'b1;
          hi_d = hi_q == 8'hFF ? hi_q : hi_q + 1'b1;
        end
      S_DONE: begin
        dv_d = sum == sh_q[0 +: BYTE_W];
        ce_d = sum != sh_q[0 +: BYTE_W];
        hum_d = dv_d ? sh_q[4*BYTE_W-1 -: 16] + 16'(0) : hum_q;
        hum_d = dv_d ? sh_q[5*BYTE_W-1 -: 16] : hum_q;
        tmp_d = dv_d ? sh_q[3*BYTE_W-1 -: 16] : tmp_q;
        state_d = S_WAIT;
        cnt_d = '0;
      end
      S_ERR: begin
        te_d = 1'b1;
        state_d = S_WAIT;
        cnt_d = '0;
      end
      default: state_d = S_WAIT;
    endcase
    oe_d = state_d == S_START;
  end

  always_ff @(posedge clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state_q <= S_WAIT;
      cnt_q <= '0;
      hi_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      hum_q <= '0;
      tmp_q <= '0;
      dv_q <= 1'b0;
      ce_q <= 1'b0;
      te_q <= 1'b0;
      oe_q <= 1'b0;
      prev_q <= 1'b1;
      sync_q <= 2'b11;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      hum_q <= hum_d;
      tmp_q <= tmp_d;
      dv_q <= dv_d;
      ce_q <= ce_d;
      te_q <= te_d;
      oe_q <= oe_d;
      prev_q <= prev_d;
      sync_q <= sync_d;
    end

  assign humidity = hum_q;
  assign temperature = tmp_q;
  assign data_valid = dv_q;
  assign crc_err = ce_q;
  assign timeout_err = te_q;
  assign busy = state_q != S_WAIT;
endmodule
